// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider (seq_divider).
//   - state_t        : FSM state encoding (IDLE=0, CALC=1, FINISH=2)
//   - DIV_WIDTH_DEFAULT : default operand width
//   - dbz_quotient() : RISC-V divide-by-zero quotient (all ones) for a width
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 24;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // All-ones value in the low 'width' bits; callers slice to their width.
    function automatic logic [31:0] dbz_quotient(input int unsigned width);
        dbz_quotient = 32'hFFFF_FFFF >> (32 - width);
    endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   i_rem     [WIDTH-1:0] : partial remainder before this step
//   i_quo     [WIDTH-1:0] : dividend/quotient shift register before this step
//   i_divisor [WIDTH-1:0] : divisor magnitude
//   o_rem     [WIDTH-1:0] : partial remainder after this step
//   o_quo     [WIDTH-1:0] : shift register after this step (new LSB = quotient bit)
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    // Remainder stays below the divisor, so WIDTH+1 bits hold the trial
    // difference and its MSB is a reliable sign.
    assign w_trial   = w_shifted - {1'b0, i_divisor};

    assign o_rem = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider, one quotient bit per clock, RISC-V DIV/REM
// result semantics for divide-by-zero and signed overflow.
// Optional feature macro: DIV_SIGNED_EN (signed operation via i_is_signed).
//
// Ports:
//   i_clk           : system clock, rising edge
//   i_rst_n         : asynchronous active-low reset
//   i_start         : request pulse, accepted only in IDLE and not while done
//   i_is_signed     : signed operation (only with DIV_SIGNED_EN)
//   i_dividend      : numerator, sampled at acceptance
//   i_divisor       : denominator, sampled at acceptance
//   o_busy          : operation in progress
//   o_done          : one-cycle pulse, results valid
//   o_quotient      : quotient, held until next done
//   o_remainder     : remainder, held until next done
//   o_div_by_zero   : last completed operation divided by zero
//
// state    | meaning
// S_IDLE   | waiting for start
// S_CALC   | one restoring iteration per clock, counter counts down
// S_FINISH | sign correction and output register load
// ---------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam logic [31:0]      DBZ_Q32 = dbz_quotient(WIDTH);
    localparam logic [WIDTH-1:0] DBZ_Q   = DBZ_Q32[WIDTH-1:0];

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_quo, w_quo_nxt;
    logic [WIDTH-1:0] r_div, w_div_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_dbz, w_dbz_nxt;
    logic [WIDTH-1:0] r_quotient, w_quotient_nxt;
    logic [WIDTH-1:0] r_remainder, w_remainder_nxt;

    logic             w_accept;
    logic [WIDTH-1:0] w_step_rem, w_step_quo;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
    logic [WIDTH-1:0] w_quo_fix, w_rem_fix, w_dvd_fix;

    // A start coinciding with done is dropped so the two never overlap.
    assign w_accept = (r_state == S_IDLE) && i_start && !r_done;

`ifdef DIV_SIGNED_EN
    logic r_negq, r_negr;
    logic w_dvd_neg, w_dvs_neg;

    assign w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
    assign w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? -i_divisor  : i_divisor;

    // Negating the magnitude restores the raw dividend (including the most
    // negative value), which is what divide-by-zero reports as remainder.
    assign w_quo_fix = r_negq ? -r_quo : r_quo;
    assign w_rem_fix = r_negr ? -r_rem : r_rem;
    assign w_dvd_fix = r_negr ? -r_quo : r_quo;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_negq <= 1'b0;
            r_negr <= 1'b0;
        end else if (w_accept) begin
            r_negq <= w_dvd_neg ^ w_dvs_neg;
            r_negr <= w_dvd_neg;
        end
    end
`else
    logic w_unused_is_signed;
    assign w_unused_is_signed = i_is_signed;

    assign w_dvd_mag = i_dividend;
    assign w_dvs_mag = i_divisor;
    assign w_quo_fix = r_quo;
    assign w_rem_fix = r_rem;
    assign w_dvd_fix = r_quo;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_quo       <= w_quo_nxt;
            r_div       <= w_div_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_dbz       <= w_dbz_nxt;
            r_quotient  <= w_quotient_nxt;
            r_remainder <= w_remainder_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_quo_nxt       = r_quo;
        w_div_nxt       = r_div;
        w_cnt_nxt       = r_cnt;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_dbz_nxt       = r_dbz;
        w_quotient_nxt  = r_quotient;
        w_remainder_nxt = r_remainder;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_quo_nxt   = w_dvd_mag;
                    w_div_nxt   = w_dvs_mag;
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = CNT_W'(WIDTH);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (i_divisor == '0) ? S_FINISH : S_CALC;
                end
            end
            S_CALC: begin
                w_rem_nxt = w_step_rem;
                w_quo_nxt = w_step_quo;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                // A zero divisor skipped CALC, so r_quo still holds the dividend.
                if (r_div == '0) begin
                    w_quotient_nxt  = DBZ_Q;
                    w_remainder_nxt = w_dvd_fix;
                    w_dbz_nxt       = 1'b1;
                end else begin
                    w_quotient_nxt  = w_quo_fix;
                    w_remainder_nxt = w_rem_fix;
                    w_dbz_nxt       = 1'b0;
                end
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=24). Vector table applied in a
// loop, expected results queued at start and compared when done pulses,
// plus hand-written handshake and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    localparam int NV = 13;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, dbz;
    logic [W-1:0] quotient, remainder;

    vec_t vecs [NV];
    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_is_signed   (is_signed),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (dbz)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got q=%h r=%h z=%b with nothing queued",
                         quotient, remainder, dbz);
            end else begin
                e = sb.pop_front();
                if (quotient !== e.q || remainder !== e.r || dbz !== e.z) begin
                    failures++;
                    $display("FAIL result got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                             quotient, remainder, dbz, e.q, e.r, e.z);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Drive one operation and follow it to done. With on_done the start is
    // raised in the done cycle of the previous op (must be dropped) and held
    // one more cycle (must be accepted). With inject, extra starts with other
    // operands are raised 3 and 10 clocks into the operation.
    task automatic run_vec(input vec_t v, input bit inject, input bit on_done);
        int  edges;
        bit  busy_ok;
        bit  seen;
        exp_t e;
        if (!on_done) @(negedge clk);
        dividend  = v.a;
        divisor   = v.b;
        is_signed = v.s;
        start     = 1'b1;
        e.q = v.q; e.r = v.r; e.z = v.z;
        sb.push_back(e);
        if (on_done) begin
            @(negedge clk);
            check("start_with_done_ignored", 32'(busy), 32'd0);
        end
        edges   = -1;
        busy_ok = 1'b1;
        seen    = 1'b0;
        while (!seen && edges < 100) begin
            @(negedge clk);
            edges++;
            start = 1'b0;
            if (inject && (edges == 3 || edges == 10)) begin
                start     = 1'b1;
                dividend  = 24'd100;
                divisor   = 24'd10;
                is_signed = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                check("busy_low_at_done", 32'(busy), 32'd0);
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout got no done expected done within 100 clocks");
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            check("latency", 32'(edges), v.z ? 32'd1 : 32'(W + 1));
            check("busy_during_op", 32'(busy_ok), 32'd1);
        end
    endtask

    initial begin
        vec_t vc;

        vecs[0]  = '{24'd1000,   24'd7,       1'b0, 24'd142,    24'd6,      1'b0};
        vecs[1]  = '{24'h00ABCD, 24'd0,       1'b0, 24'hFFFFFF, 24'h00ABCD, 1'b1};
        vecs[2]  = '{24'hFFFFF9, 24'd2,       1'b0, 24'h7FFFFC, 24'd1,      1'b0};
        vecs[3]  = '{24'd100,    24'd10,      1'b0, 24'd10,     24'd0,      1'b0};
        vecs[4]  = '{24'hFFFFFF, 24'd1,       1'b0, 24'hFFFFFF, 24'd0,      1'b0};
        vecs[5]  = '{24'd5,      24'hFFFFFF,  1'b0, 24'd0,      24'd5,      1'b0};
        vecs[6]  = '{24'hFFFFFF, 24'hFFFFFF,  1'b0, 24'd1,      24'd0,      1'b0};
        vecs[7]  = '{24'd0,      24'd5,       1'b0, 24'd0,      24'd0,      1'b0};
        vecs[8]  = '{24'd0,      24'd0,       1'b0, 24'hFFFFFF, 24'd0,      1'b1};
        vecs[9]  = '{24'd123456, 24'd789,     1'b0, 24'd156,    24'd372,    1'b0};
        vecs[10] = '{24'hFFFFF8, 24'd0,       1'b1, 24'hFFFFFF, 24'hFFFFF8, 1'b1};
`ifdef DIV_SIGNED_EN
        vecs[11] = '{24'hFFFFF9, 24'd2,       1'b1, 24'hFFFFFD, 24'hFFFFFF, 1'b0};
        vecs[12] = '{24'h800000, 24'hFFFFFF,  1'b1, 24'h800000, 24'd0,      1'b0};
`else
        vecs[11] = '{24'hFFFFF9, 24'd2,       1'b1, 24'h7FFFFC, 24'd1,      1'b0};
        vecs[12] = '{24'h800000, 24'hFFFFFF,  1'b1, 24'd0,      24'h800000, 1'b0};
`endif

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_dbz", 32'(dbz), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], 1'b0, 1'b0);
        end

        // Starts while busy are ignored; start in done cycle dropped, next cycle taken.
        run_vec(vecs[0], 1'b1, 1'b0);
        run_vec(vecs[9], 1'b0, 1'b1);

        // Reset twelve clocks into an operation: aborted, no done, outputs cleared.
        @(negedge clk);
        dividend = 24'd1000;
        divisor  = 24'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        repeat (30) @(negedge clk);
        rst_n = 1'b1;
        vc = vecs[3];
        run_vec(vc, 1'b0, 1'b0);

        repeat (40) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
